// File: rtl/operand_read_stage.sv
// operand_read_stage: reads PRF operands with same-cycle writeback bypass into a single-entry FU pipe register.
module operand_read_stage #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 7,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [PREG_W-1:0] iss_ps1,
    input  logic [PREG_W-1:0] iss_ps2,
    input  logic [PREG_W-1:0] iss_pd,
    input  logic [DATA_W-1:0] iss_imm,
    input  logic [CTRL_W-1:0] iss_ctrl,
    output logic              prf_rd_en,
    output logic [PREG_W-1:0] prf_ps1,
    output logic [PREG_W-1:0] prf_ps2,
    input  logic [DATA_W-1:0] prf_ps1_data,
    input  logic [DATA_W-1:0] prf_ps2_data,
    input  logic              wb_alu_en,
    input  logic              wb_b_en,
    input  logic              wb_mem_en,
    input  logic [PREG_W-1:0] wb_alu_pd,
    input  logic [PREG_W-1:0] wb_b_pd,
    input  logic [PREG_W-1:0] wb_mem_pd,
    input  logic [DATA_W-1:0] wb_alu_data,
    input  logic [DATA_W-1:0] wb_b_data,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic              flush,
    output logic              fu_valid,
    input  logic              fu_ready,
    output logic [DATA_W-1:0] fu_op1,
    output logic [DATA_W-1:0] fu_op2,
    output logic [DATA_W-1:0] fu_imm,
    output logic [PREG_W-1:0] fu_pd,
    output logic [CTRL_W-1:0] fu_ctrl,
    output logic [31:0]       issue_cnt
);
    logic              accept;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    // Tag 0 is hardwired zero; bypass priority alu > b > mem.
    function automatic logic [DATA_W-1:0] fwd(input logic [PREG_W-1:0] tag, input logic [DATA_W-1:0] rd);
        return (tag == '0) ? '0 :
               (wb_alu_en && wb_alu_pd == tag) ? wb_alu_data :
               (wb_b_en && wb_b_pd == tag) ? wb_b_data :
               (wb_mem_en && wb_mem_pd == tag) ? wb_mem_data : rd;
    endfunction

    always_comb begin
        iss_ready = reset_n && (!fu_valid || fu_ready);
        accept    = iss_valid && iss_ready && !flush;
        prf_rd_en = accept;
        prf_ps1   = iss_ps1;
        prf_ps2   = iss_ps2;
        op1       = fwd(iss_ps1, prf_ps1_data);
        op2       = fwd(iss_ps2, prf_ps2_data);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fu_valid  <= 1'b0;
            fu_op1    <= '0;
            fu_op2    <= '0;
            fu_imm    <= '0;
            fu_pd     <= '0;
            fu_ctrl   <= '0;
            issue_cnt <= '0;
        end else begin
            if (accept) begin
                fu_op1    <= op1;
                fu_op2    <= op2;
                fu_imm    <= iss_imm;
                fu_pd     <= iss_pd;
                fu_ctrl   <= iss_ctrl;
                issue_cnt <= issue_cnt + 32'd1;
            end
            fu_valid <= flush ? 1'b0 : accept ? 1'b1 : (fu_ready ? 1'b0 : fu_valid);
        end
    end
endmodule

// File: tb/tb_operand_read_stage.sv
// tb_operand_read_stage: directed checks of operand read, bypass, stall, flush and reset behaviour.
module tb_operand_read_stage;
    logic        clk = 0;
    logic        reset_n;
    logic        iss_valid, iss_ready;
    logic [6:0]  iss_ps1, iss_ps2, iss_pd;
    logic [31:0] iss_imm;
    logic [15:0] iss_ctrl;
    logic        prf_rd_en;
    logic [6:0]  prf_ps1, prf_ps2;
    logic [31:0] prf_ps1_data, prf_ps2_data;
    logic        wb_alu_en, wb_b_en, wb_mem_en;
    logic [6:0]  wb_alu_pd, wb_b_pd, wb_mem_pd;
    logic [31:0] wb_alu_data, wb_b_data, wb_mem_data;
    logic        flush, fu_valid, fu_ready;
    logic [31:0] fu_op1, fu_op2, fu_imm;
    logic [6:0]  fu_pd;
    logic [15:0] fu_ctrl;
    logic [31:0] issue_cnt;
    logic [31:0] prf [128];
    int errors = 0;
    int checks = 0;

    assign prf_ps1_data = prf[prf_ps1];
    assign prf_ps2_data = prf[prf_ps2];

    always #5 clk = ~clk;

    operand_read_stage dut (
        .clk(clk), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
        .iss_imm(iss_imm), .iss_ctrl(iss_ctrl),
        .prf_rd_en(prf_rd_en), .prf_ps1(prf_ps1), .prf_ps2(prf_ps2),
        .prf_ps1_data(prf_ps1_data), .prf_ps2_data(prf_ps2_data),
        .wb_alu_en(wb_alu_en), .wb_b_en(wb_b_en), .wb_mem_en(wb_mem_en),
        .wb_alu_pd(wb_alu_pd), .wb_b_pd(wb_b_pd), .wb_mem_pd(wb_mem_pd),
        .wb_alu_data(wb_alu_data), .wb_b_data(wb_b_data), .wb_mem_data(wb_mem_data),
        .flush(flush), .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_op1(fu_op1), .fu_op2(fu_op2), .fu_imm(fu_imm),
        .fu_pd(fu_pd), .fu_ctrl(fu_ctrl), .issue_cnt(issue_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] pd,
                         input logic [31:0] imm, input logic [15:0] ctrl);
        iss_valid = 1; iss_ps1 = p1; iss_ps2 = p2; iss_pd = pd; iss_imm = imm; iss_ctrl = ctrl;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) prf[i] = 32'h0;
        reset_n = 0; flush = 0; fu_ready = 1;
        wb_alu_en = 0; wb_b_en = 0; wb_mem_en = 0;
        wb_alu_pd = 0; wb_b_pd = 0; wb_mem_pd = 0;
        wb_alu_data = 0; wb_b_data = 0; wb_mem_data = 0;
        issue(7'd1, 7'd2, 7'd3, 32'h5, 16'h5);
        #1;
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_prf_rd_en", prf_rd_en, 0);
        step(); step();
        chk("rst_fu_valid", fu_valid, 0);
        chk("rst_cnt", issue_cnt, 0);
        chk("rst_op1", fu_op1, 0);
        reset_n = 1; iss_valid = 0;
        step();
        chk("post_rst_fu_valid", fu_valid, 0);

        // Plain PRF read
        prf[5] = 32'h11; prf[6] = 32'h22;
        issue(7'd5, 7'd6, 7'd10, 32'h1234, 16'h00A5);
        #1;
        chk("basic_rd_en", prf_rd_en, 1);
        chk("basic_prf_ps1", prf_ps1, 5);
        chk("basic_prf_ps2", prf_ps2, 6);
        step();
        iss_valid = 0;
        chk("basic_valid", fu_valid, 1);
        chk("basic_op1", fu_op1, 32'h11);
        chk("basic_op2", fu_op2, 32'h22);
        chk("basic_imm", fu_imm, 32'h1234);
        chk("basic_pd", fu_pd, 10);
        chk("basic_ctrl", fu_ctrl, 16'h00A5);
        chk("basic_cnt", issue_cnt, 1);
        step();
        chk("drain_valid", fu_valid, 0);
        chk("drain_op1_hold", fu_op1, 32'h11);

        // b and mem bypass
        prf[9] = 0;
        issue(7'd9, 7'd6, 7'd11, 32'h0, 16'h1);
        wb_b_en = 1; wb_b_pd = 9; wb_b_data = 32'hBEEF;
        wb_mem_en = 1; wb_mem_pd = 6; wb_mem_data = 32'h66;
        step();
        iss_valid = 0; wb_b_en = 0; wb_mem_en = 0;
        chk("bypb_op1", fu_op1, 32'hBEEF);
        chk("bypm_op2", fu_op2, 32'h66);
        chk("byp_cnt", issue_cnt, 2);

        // Tag zero ignores PRF and bypass
        prf[0] = 32'h999;
        issue(7'd0, 7'd0, 7'd0, 32'h0, 16'h2);
        wb_alu_en = 1; wb_alu_pd = 0; wb_alu_data = 32'hFFFF;
        step();
        chk("zero_op1", fu_op1, 0);
        chk("zero_op2", fu_op2, 0);
        chk("zero_valid", fu_valid, 1);
        chk("zero_cnt", issue_cnt, 3);

        // Bypass priority, back-to-back with a valid entry draining
        issue(7'd7, 7'd8, 7'd4, 32'h44, 16'h3);
        wb_alu_en = 1; wb_alu_pd = 7; wb_alu_data = 32'hA1;
        wb_b_en = 1; wb_b_pd = 7; wb_b_data = 32'hB1;
        wb_mem_en = 1; wb_mem_pd = 7; wb_mem_data = 32'hC1;
        #1;
        chk("b2b_ready", iss_ready, 1);
        wb_b_pd = 8; wb_b_data = 32'hB2; wb_mem_pd = 8; wb_mem_data = 32'hC2;
        #1;
        wb_b_pd = 7; wb_b_data = 32'hB1;
        wb_mem_pd = 8; wb_mem_data = 32'hC2;
        wb_b_en = 1;
        // alu wins op1 (7); op2 (8) sees only mem since b now targets 7
        step();
        chk("pri_op1", fu_op1, 32'hA1);
        chk("pri_op2", fu_op2, 32'hC2);
        chk("pri_cnt", issue_cnt, 4);

        // Stall: no accept, outputs frozen, late writeback ignored
        fu_ready = 0; wb_b_en = 0; wb_mem_en = 0;
        wb_alu_en = 1; wb_alu_pd = 7; wb_alu_data = 32'hDD;
        prf[9] = 32'h99;
        issue(7'd9, 7'd5, 7'd12, 32'h77, 16'h4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", iss_ready, 0);
            chk("stall_rd_en", prf_rd_en, 0);
            step();
            chk("stall_valid", fu_valid, 1);
            chk("stall_op1", fu_op1, 32'hA1);
            chk("stall_pd", fu_pd, 4);
            chk("stall_cnt", issue_cnt, 4);
        end
        fu_ready = 1;
        #1;
        chk("unstall_ready", iss_ready, 1);
        step();
        iss_valid = 0; wb_alu_en = 0;
        chk("unstall_valid", fu_valid, 1);
        chk("unstall_op1", fu_op1, 32'h99);
        chk("unstall_op2", fu_op2, 32'h11);
        chk("unstall_pd", fu_pd, 12);
        chk("unstall_cnt", issue_cnt, 5);

        // Flush beats accept and a stalled entry
        fu_ready = 0; flush = 1;
        issue(7'd5, 7'd6, 7'd1, 32'h0, 16'h5);
        #1;
        chk("flush_rd_en", prf_rd_en, 0);
        step();
        flush = 0; iss_valid = 0; fu_ready = 1;
        chk("flush_valid", fu_valid, 0);
        chk("flush_cnt", issue_cnt, 5);

        // Reset mid-stall
        issue(7'd5, 7'd6, 7'd2, 32'h88, 16'h6);
        step();
        iss_valid = 0; fu_ready = 0;
        chk("pre_rst_valid", fu_valid, 1);
        chk("pre_rst_cnt", issue_cnt, 6);
        step();
        reset_n = 0;
        issue(7'd5, 7'd6, 7'd3, 32'h1, 16'h1);
        #1;
        chk("midrst_ready", iss_ready, 0);
        step();
        chk("midrst_valid", fu_valid, 0);
        chk("midrst_op1", fu_op1, 0);
        chk("midrst_op2", fu_op2, 0);
        chk("midrst_imm", fu_imm, 0);
        chk("midrst_pd", fu_pd, 0);
        chk("midrst_ctrl", fu_ctrl, 0);
        chk("midrst_cnt", issue_cnt, 0);
        chk("midrst_ready2", iss_ready, 0);
        reset_n = 1; iss_valid = 0;
        #1;
        chk("rel_ready", iss_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_read_stage.md
OPERAND_READ_STAGE -- requirements
Module: operand_read_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result data width.
REQ-002 SHALL have parameter PREG_W, default 7, physical register tag width (128 entries).
REQ-003 SHALL have parameter CTRL_W, default 16, opaque FU control payload width.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state on rising edge; reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: iss_valid  in  1  RS issue request; iss_ready  out  1  stage accepts issue; iss_ps1, iss_ps2, iss_pd  in  PREG_W  source/dest tags; iss_imm  in  DATA_W  immediate; iss_ctrl  in  CTRL_W  payload.
REQ-006 SHALL have ports: prf_rd_en  out  1  PRF read enable; prf_ps1, prf_ps2  out  PREG_W  PRF read tags; prf_ps1_data, prf_ps2_data  in  DATA_W  combinational PRF read data.
REQ-007 SHALL have ports: wb_alu_en, wb_b_en, wb_mem_en  in  1  same-cycle PRF write strobes; wb_alu_pd, wb_b_pd, wb_mem_pd  in  PREG_W; wb_alu_data, wb_b_data, wb_mem_data  in  DATA_W.
REQ-008 SHALL have ports: flush  in  1  pipeline kill; fu_valid  out  1; fu_ready  in  1; fu_op1, fu_op2, fu_imm  out  DATA_W; fu_pd  out  PREG_W; fu_ctrl  out  CTRL_W; issue_cnt  out  32  accepted-issue counter.

Function
REQ-009 SHALL define accept = iss_valid && iss_ready && !flush.
REQ-010 SHALL drive iss_ready = !fu_valid || fu_ready (single-entry pipe register, pass-through ready).
REQ-011 SHALL drive prf_rd_en = accept and prf_ps1/prf_ps2 = iss_ps1/iss_ps2 combinationally.
REQ-012 SHALL form each operand in the accept cycle: tag 0 -> 0; else wb port with en && pd==tag && pd!=0 -> that wb data; else PRF read data.
REQ-013 SHALL resolve multiple bypass matches with priority alu > b > mem (illegal upstream, but deterministic).
REQ-014 SHALL register operands, iss_imm, iss_pd, iss_ctrl into fu_* on accept; fu_valid set the following cycle (latency exactly 1).
REQ-015 SHALL hold all fu_* outputs stable while fu_valid && !fu_ready.
REQ-016 SHALL clear fu_valid on the cycle after fu_valid && fu_ready with no accept; with accept in same cycle, fu_valid stays 1 with new data.
REQ-017 SHALL, on flush, clear fu_valid next cycle regardless of fu_ready and discard any same-cycle issue; flush has priority over accept.
REQ-018 SHALL increment issue_cnt by 1 per accept, wrapping 0xFFFFFFFF -> 0.
REQ-019 SHALL not modify fu_op1/fu_op2 data while held; captured values are final (no late bypass).

Reset
REQ-020 SHALL, when reset_n==0 at a rising edge, clear fu_valid, fu_op1, fu_op2, fu_imm, fu_pd, fu_ctrl, issue_cnt to 0.
REQ-021 SHALL force iss_ready=0 and prf_rd_en=0 while reset_n==0; an issue during reset is dropped.
REQ-022 SHALL discard an in-flight held entry on reset mid-stall (fu_valid=0 after edge).

Verification
REQ-023 Issue ps1=5, ps2=6, PRF[5]=0x11, PRF[6]=0x22, fu_ready=1 -> next cycle fu_valid=1, fu_op1=0x11, fu_op2=0x22, issue_cnt=1.
REQ-024 Issue ps1=9 with wb_b_en=1, wb_b_pd=9, wb_b_data=0xBEEF same cycle, PRF[9]=0 -> fu_op1=0xBEEF.
REQ-025 Issue ps1=0, ps2=0 with wb_alu_en=1, wb_alu_pd=0, data 0xFFFF -> fu_op1=fu_op2=0.
REQ-026 fu_valid=1, fu_ready=0 for 3 cycles, new iss_valid=1 -> iss_ready=0, fu_* unchanged, issue_cnt unchanged; fu_ready=1 -> accept, next data out following cycle.
REQ-027 flush=1 with iss_valid=1 and fu_valid=1 -> next cycle fu_valid=0, issue_cnt unchanged.
REQ-028 reset_n=0 during stall with fu_valid=1 -> after edge all outputs 0, iss_ready=0 until reset_n=1.
